// File: rtl/hazard_ctrl_param_pkg.sv
// Shared types and default stage indices for the RV32I pipeline hazard controller.
// Contents:
//   lsu_wait_state_e - LSU handshake watchdog FSM states
//   DEF_*            - default pipeline-register indices and counts
package singlecycle_pkg;

    typedef enum logic {
        L_IDLE,
        L_WAIT
    } lsu_wait_state_e;

    localparam int unsigned DEF_N_STG      = 4;   // IF/ID, ID/EX, EX/MEM, MEM/WB
    localparam int unsigned DEF_BR_STG     = 2;   // EX redirect flushes IF/ID and ID/EX
    localparam int unsigned DEF_LSU_STG    = 2;   // EX/MEM holds the LSU instruction
    localparam int unsigned DEF_LD_USE_LAT = 1;
    localparam int unsigned DEF_LSU_TO     = 255;
    localparam int unsigned DEF_CNT_W      = 32;

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// Hazard-controller bundle: hazard sources from the datapath and the
// enable/flush/status signals returned to the stage registers.
// Modports:
//   master - datapath side (drives hazard sources, receives enables/flushes)
//   slave  - hazard controller side
interface hazard_ctrl_param_if
    import singlecycle_pkg::*;
#(
    parameter int unsigned N_STG = DEF_N_STG,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             i_is_pred_taken;
    logic             i_is_jal_inst;
    logic             i_is_pred_wrong;
    logic             i_is_jalr_inst;
    logic             i_is_depend_load;
    logic             i_is_fwd_from_WB_to_EX;
    logic             i_lsu_VALID;
    logic             i_lsu_READY;
    logic             o_pc_en;
    logic [N_STG-1:0] o_dreg_en;
    logic [N_STG-1:0] o_creg_en;
    logic [N_STG-1:0] o_flush;
    logic             o_lsu_busy;
    logic             o_lsu_timeout;
    logic [CNT_W-1:0] o_perf_stall_cnt;
    logic [CNT_W-1:0] o_perf_flush_cnt;

    modport master (
        output i_is_pred_taken, i_is_jal_inst, i_is_pred_wrong, i_is_jalr_inst,
               i_is_depend_load, i_is_fwd_from_WB_to_EX, i_lsu_VALID, i_lsu_READY,
        input  o_pc_en, o_dreg_en, o_creg_en, o_flush, o_lsu_busy, o_lsu_timeout,
               o_perf_stall_cnt, o_perf_flush_cnt
    );

    modport slave (
        input  i_is_pred_taken, i_is_jal_inst, i_is_pred_wrong, i_is_jalr_inst,
               i_is_depend_load, i_is_fwd_from_WB_to_EX, i_lsu_VALID, i_lsu_READY,
        output o_pc_en, o_dreg_en, o_creg_en, o_flush, o_lsu_busy, o_lsu_timeout,
               o_perf_stall_cnt, o_perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_param_perf_cnt.sv
// hazard_perf_cnt: free-running wrap-around event counter.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - count this cycle
//   cnt   - current count
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: pipeline hazard controller for an N_STG-register RV32I pipeline.
// Produces PC enable, per-register enables and flushes (combinational), the LSU
// busy flag, a sticky LSU timeout flag and optional perf counters.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   bus     - hazard_ctrl_param_if.slave (hazard sources in, enables/flushes out)
// Build option: define HAZARD_PERF_CNT_EN to enable the stall/flush perf counters;
// otherwise both counter outputs are tied to 0.
module hazard_ctrl_param
    import singlecycle_pkg::*;
#(
    parameter int unsigned N_STG      = DEF_N_STG,
    parameter int unsigned BR_STG     = DEF_BR_STG,
    parameter int unsigned LSU_STG    = DEF_LSU_STG,
    parameter int unsigned LD_USE_LAT = DEF_LD_USE_LAT,
    parameter int unsigned LSU_TO     = DEF_LSU_TO,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input logic              i_clk,
    input logic              i_rst_n,
    hazard_ctrl_param_if.slave bus
);
    localparam int unsigned LCW = (LD_USE_LAT > 1) ? $clog2(LD_USE_LAT) : 1;
    localparam int unsigned WCW = (LSU_TO > 1) ? $clog2(LSU_TO + 1) : 1;
    localparam logic [LCW-1:0] LD_RELOAD = LCW'(LD_USE_LAT - 1);
    localparam logic [WCW-1:0] TO_W      = WCW'(LSU_TO);

    logic             lsu_stall;
    logic             ld_stall;
    logic             pc_en;
    logic [N_STG-1:0] en;
    logic [N_STG-1:0] flush;

    logic [LCW-1:0]  ld_cnt_q, ld_cnt_d;
    lsu_wait_state_e state_q, state_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    // Enable/flush merge: each source clears enables and sets flushes.
    always_comb begin
        lsu_stall = bus.i_lsu_VALID & ~bus.i_lsu_READY;
        ld_stall  = (ld_cnt_q != '0) | bus.i_is_depend_load;
        pc_en     = 1'b1;
        en        = '1;
        flush     = '0;

        if (bus.i_is_pred_taken | bus.i_is_jal_inst) begin
            flush[0] = 1'b1;
        end
        if (bus.i_is_pred_wrong | bus.i_is_jalr_inst) begin
            for (int unsigned i = 0; i < BR_STG; i++) flush[i] = 1'b1;
        end
        if (lsu_stall) begin
            pc_en = 1'b0;
            for (int unsigned i = 0; i <= LSU_STG; i++) en[i] = 1'b0;
            flush[LSU_STG+1] = 1'b1;
        end
        if (ld_stall) begin
            pc_en    = 1'b0;
            en[0]    = 1'b0;
            flush[1] = 1'b1;
        end
        // The WB value being forwarded into a held EX stage would retire while EX waits.
        if (bus.i_is_fwd_from_WB_to_EX & ~en[1] & en[N_STG-1]) begin
            pc_en = 1'b0;
            en    = '0;
        end
    end

    // Load-use counter: reloads only when idle, frozen while the LSU stalls.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (ld_cnt_q == '0) begin
            ld_cnt_d = bus.i_is_depend_load ? LD_RELOAD : '0;
        end else if (!lsu_stall) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
        end
    end

    // LSU watchdog FSM with saturating wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        unique case (state_q)
            L_IDLE: if (lsu_stall) state_d = L_WAIT;
            L_WAIT: if (bus.i_lsu_READY || !bus.i_lsu_VALID) state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
        if (state_q == L_WAIT && state_d == L_WAIT) begin
            wait_cnt_d = (wait_cnt_q == TO_W) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_d == TO_W) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ld_cnt_q   <= '0;
            state_q    <= L_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            ld_cnt_q   <= ld_cnt_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.o_pc_en       = pc_en;
    assign bus.o_dreg_en     = en;
    assign bus.o_creg_en     = en;
    assign bus.o_flush       = flush;
    assign bus.o_lsu_busy    = lsu_stall;
    assign bus.o_lsu_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (~pc_en),
        .cnt   (bus.o_perf_stall_cnt)
    );

    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (|flush),
        .cnt   (bus.o_perf_flush_cnt)
    );
`else
    assign bus.o_perf_stall_cnt = {CNT_W{1'b0}};
    assign bus.o_perf_flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed bench for hazard_ctrl_param with N_STG=4, BR_STG=2, LSU_STG=2,
// LD_USE_LAT=3, LSU_TO=8. Input pattern bits: {pt, jal, pw, jalr, dl, fwd, valid, ready}.
module tb_hazard_ctrl_param;
    localparam int unsigned CNT_W = 32;

    typedef struct {
        string      name;
        logic [7:0] in;
        logic       pc;
        logic [3:0] en;
        logic [3:0] fl;
        logic       busy;
    } vec_t;

    logic i_clk;
    logic i_rst_n;
    int   n_vec;
    int   n_err;
    int   exp_stall;
    int   exp_flush;

    hazard_ctrl_param_if #(.N_STG(4), .CNT_W(CNT_W)) bus ();

    hazard_ctrl_param #(
        .N_STG      (4),
        .BR_STG     (2),
        .LSU_STG    (2),
        .LD_USE_LAT (3),
        .LSU_TO     (8),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic drive(input logic [7:0] in);
        bus.i_is_pred_taken        = in[7];
        bus.i_is_jal_inst          = in[6];
        bus.i_is_pred_wrong        = in[5];
        bus.i_is_jalr_inst         = in[4];
        bus.i_is_depend_load       = in[3];
        bus.i_is_fwd_from_WB_to_EX = in[2];
        bus.i_lsu_VALID            = in[1];
        bus.i_lsu_READY            = in[0];
    endtask

    task automatic check_out(input string name, input logic pc, input logic [3:0] en,
                             input logic [3:0] fl, input logic busy);
        logic [13:0] act;
        logic [13:0] exp;
        act = {bus.o_pc_en, bus.o_dreg_en, bus.o_creg_en, bus.o_flush, bus.o_lsu_busy};
        exp = {pc, en, en, fl, busy};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {pc,dreg,creg,flush,busy} got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                     name, act[13], act[12:9], act[8:5], act[4:1], act[0],
                     pc, en, en, fl, busy);
        end
    endtask

    task automatic check_val(input string name, input logic [CNT_W-1:0] act,
                             input logic [CNT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare, and account for the posedge that follows.
    task automatic step(input string name, input logic [7:0] in, input logic pc,
                        input logic [3:0] en, input logic [3:0] fl, input logic busy);
        @(negedge i_clk);
        drive(in);
        #1;
        check_out(name, pc, en, fl, busy);
        if (!pc) exp_stall++;
        if (fl != 4'b0000) exp_flush++;
    endtask

    vec_t tbl[14];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_stall = 0;
        exp_flush = 0;

        tbl[0]  = '{"idle",          8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0};
        tbl[1]  = '{"pred_taken",    8'b1000_0000, 1'b1, 4'b1111, 4'b0001, 1'b0};
        tbl[2]  = '{"jal",           8'b0100_0000, 1'b1, 4'b1111, 4'b0001, 1'b0};
        tbl[3]  = '{"pred_wrong",    8'b0010_0000, 1'b1, 4'b1111, 4'b0011, 1'b0};
        tbl[4]  = '{"jalr",          8'b0001_0000, 1'b1, 4'b1111, 4'b0011, 1'b0};
        tbl[5]  = '{"id_and_ex",     8'b1010_0000, 1'b1, 4'b1111, 4'b0011, 1'b0};
        tbl[6]  = '{"lsu_stall",     8'b0000_0010, 1'b0, 4'b1000, 4'b1000, 1'b0 | 1'b1};
        tbl[7]  = '{"lsu_ready",     8'b0000_0011, 1'b1, 4'b1111, 4'b0000, 1'b0};
        tbl[8]  = '{"lsu_plus_ex",   8'b0010_0010, 1'b0, 4'b1000, 4'b1011, 1'b1};
        tbl[9]  = '{"fwd_only",      8'b0000_0100, 1'b1, 4'b1111, 4'b0000, 1'b0};
        tbl[10] = '{"fwd_hold_all",  8'b0000_0110, 1'b0, 4'b0000, 4'b1000, 1'b1};
        tbl[11] = '{"fwd_id_redir",  8'b1000_0100, 1'b1, 4'b1111, 4'b0001, 1'b0};
        tbl[12] = '{"fwd_hold_jal",  8'b0100_0110, 1'b0, 4'b0000, 4'b1001, 1'b1};
        tbl[13] = '{"idle_end",      8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0};

        // Reset state
        drive(8'b0);
        i_rst_n = 1'b0;
        #12;
        check_out("reset_outputs", 1'b1, 4'b1111, 4'b0000, 1'b0);
        check_val("reset_timeout", {31'b0, bus.o_lsu_timeout}, 32'd0);
        check_val("reset_perf_stall", bus.o_perf_stall_cnt, 32'd0);
        check_val("reset_perf_flush", bus.o_perf_flush_cnt, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].name, tbl[i].in, tbl[i].pc, tbl[i].en, tbl[i].fl, tbl[i].busy);
        end

        // Load-use pulse: three stall cycles, normal on the fourth
        step("ld_pulse_c1", 8'b0000_1000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_pulse_c2", 8'b0000_0000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_pulse_c3", 8'b0000_0000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_pulse_c4", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);

        // A repeated depend_load while counting does not extend the stall
        step("ld_rep_c1", 8'b0000_1000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_rep_c2", 8'b0000_1000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_rep_c3", 8'b0000_0000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_rep_c4", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);

        // Load-use counter freezes across an LSU stall
        step("ld_frz_c1", 8'b0000_1000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_frz_c2", 8'b0000_0010, 1'b0, 4'b1000, 4'b1010, 1'b1);
        step("ld_frz_c3", 8'b0000_0010, 1'b0, 4'b1000, 4'b1010, 1'b1);
        step("ld_frz_c4", 8'b0000_0000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_frz_c5", 8'b0000_0000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        step("ld_frz_c6", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);

        // Four-cycle LSU wait, then READY
        for (int i = 0; i < 4; i++) begin
            step($sformatf("lsu4_c%0d", i), 8'b0000_0010, 1'b0, 4'b1000, 4'b1000, 1'b1);
        end
        step("lsu4_ready", 8'b0000_0011, 1'b1, 4'b1111, 4'b0000, 1'b0);
        check_val("lsu4_no_timeout", {31'b0, bus.o_lsu_timeout}, 32'd0);

        // Ten-cycle LSU wait: timeout appears after eight cycles in L_WAIT
        for (int i = 0; i < 10; i++) begin
            step($sformatf("lsu10_c%0d", i), 8'b0000_0010, 1'b0, 4'b1000, 4'b1000, 1'b1);
            check_val($sformatf("timeout_c%0d", i), {31'b0, bus.o_lsu_timeout},
                      (i >= 9) ? 32'd1 : 32'd0);
        end
        step("lsu10_release", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);
        check_val("timeout_sticky_a", {31'b0, bus.o_lsu_timeout}, 32'd1);
        step("ex_redirect", 8'b0010_0000, 1'b1, 4'b1111, 4'b0011, 1'b0);
        step("idle_after", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);
        check_val("timeout_sticky_b", {31'b0, bus.o_lsu_timeout}, 32'd1);

        @(negedge i_clk);
`ifdef HAZARD_PERF_CNT_EN
        check_val("perf_stall", bus.o_perf_stall_cnt, CNT_W'(exp_stall));
        check_val("perf_flush", bus.o_perf_flush_cnt, CNT_W'(exp_flush));
`else
        check_val("perf_stall_off", bus.o_perf_stall_cnt, 32'd0);
        check_val("perf_flush_off", bus.o_perf_flush_cnt, 32'd0);
`endif

        // Reset in the middle of a load-use stall releases it at once
        step("ld_mid_c1", 8'b0000_1000, 1'b0, 4'b1110, 4'b0010, 1'b0);
        @(negedge i_clk);
        drive(8'b0);
        #1;
        check_out("ld_mid_c2", 1'b0, 4'b1110, 4'b0010, 1'b0);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_out("ld_mid_reset", 1'b1, 4'b1111, 4'b0000, 1'b0);
        check_val("reset_clears_timeout", {31'b0, bus.o_lsu_timeout}, 32'd0);
        check_val("reset_clears_stall_cnt", bus.o_perf_stall_cnt, 32'd0);
        check_val("reset_clears_flush_cnt", bus.o_perf_flush_cnt, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step("post_reset_idle", 8'b0000_0000, 1'b1, 4'b1111, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
